// File: rtl/fft_writeback_addr_gen_if.sv
// Butterfly-result handshake and RAM write port bundle for fft_writeback_addr_gen.
interface fft_writeback_addr_gen_if #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 32
);
  logic              bf_valid;
  logic              bf_ready;
  logic [DATA_W-1:0] bf_x;
  logic [DATA_W-1:0] bf_y;
  logic              en_wr;
  logic [SIZE-1:0]   wr_ptr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output bf_valid, bf_x, bf_y,
    input  bf_ready, en_wr, wr_ptr, wr_data
  );

  modport slave (
    input  bf_valid, bf_x, bf_y,
    output bf_ready, en_wr, wr_ptr, wr_data
  );
endinterface

// File: rtl/fft_writeback_addr_gen.sv
// In-place write-back address generator for one radix-2 FFT stage.
// Define WB_OVERRUN_CHECK_EN to build the sticky overrun_err protocol check.
//
// state | meaning
// IDLE  | waiting for start_stage, not accepting pairs
// ARMED | accepting pairs, nothing to write yet
// WR_X  | writing top output of the head pair
// WR_Y  | writing bottom output, popping the head pair
// DONE  | all N words written, stage_done pulse being issued
module fft_writeback_addr_gen #(
  parameter int stage_FFT  = 2,
  parameter int N          = 16,
  parameter int SIZE       = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_stage,
  fft_writeback_addr_gen_if.slave bus,
  output logic                    stage_done,
  output logic                    overrun_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SH = stage_FFT - 1;
  localparam logic [SIZE-1:0] HALF     = SIZE'(1 << SH);
  localparam logic [SIZE-1:0] ACC_MAX  = SIZE'(N / 2);
  localparam logic [SIZE-1:0] LAST_BF  = SIZE'(N / 2 - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARMED, WR_X, WR_Y, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_x [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_y [FIFO_DEPTH];
  logic [PW-1:0]     rd_idx, wr_idx;
  logic [CW-1:0]     fifo_cnt, cnt_next;
  logic [SIZE-1:0]   acc_cnt, acc_next, wr_cnt;
  logic [SIZE-1:0]   k, top, bottom;

  logic              ready_q, ready_d;
  logic              en_wr_q, en_wr_d;
  logic [SIZE-1:0]   wr_ptr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q, done_d;
  logic              push, pop, clear, armed_next;

  assign bus.bf_ready = ready_q;
  assign bus.en_wr    = en_wr_q;
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.wr_data  = wr_data_q;
  assign stage_done   = done_q;

  // Butterfly b = wr_cnt: top = ((b >> (s-1)) << s) + (b mod half)
  assign k      = wr_cnt & (HALF - SIZE'(1));
  assign top    = ((wr_cnt >> SH) << stage_FFT) + k;
  assign bottom = top + HALF;

  assign push     = bus.bf_valid & ready_q;
  assign pop      = (state_q == WR_Y);
  assign cnt_next = clear ? '0 : fifo_cnt + CW'(push) - CW'(pop);
  assign acc_next = clear ? '0 : acc_cnt + SIZE'(push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    en_wr_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stage) begin
          state_d = ARMED;
          clear   = 1'b1;
        end
      end
      ARMED: begin
        if (fifo_cnt != '0) state_d = WR_X;
      end
      WR_X: begin
        en_wr_d = 1'b1;
        state_d = WR_Y;
      end
      WR_Y: begin
        en_wr_d = 1'b1;
        if (wr_cnt == LAST_BF)    state_d = DONE;
        else if (cnt_next != '0)  state_d = WR_X;
        else                      state_d = ARMED;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    armed_next = (state_d == ARMED) || (state_d == WR_X) || (state_d == WR_Y);
    ready_d    = armed_next && (cnt_next != CNT_FULL) && (acc_next < ACC_MAX);
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_idx] <= bus.bf_x;
      mem_y[wr_idx] <= bus.bf_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx    <= '0;
      wr_idx    <= '0;
      fifo_cnt  <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      ready_q   <= 1'b0;
      en_wr_q   <= 1'b0;
      wr_ptr_q  <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      fifo_cnt <= cnt_next;
      acc_cnt  <= acc_next;
      if (clear) begin
        rd_idx <= '0;
        wr_idx <= '0;
        wr_cnt <= '0;
      end else begin
        if (push) wr_idx <= wr_idx + PW'(1);
        if (pop) begin
          rd_idx <= rd_idx + PW'(1);
          wr_cnt <= wr_cnt + SIZE'(1);
        end
      end
      ready_q <= ready_d;
      en_wr_q <= en_wr_d;
      done_q  <= done_d;
      if (state_q == WR_X) begin
        wr_ptr_q  <= top;
        wr_data_q <= mem_x[rd_idx];
      end else if (state_q == WR_Y) begin
        wr_ptr_q  <= bottom;
        wr_data_q <= mem_y[rd_idx];
      end
    end
  end

`ifdef WB_OVERRUN_CHECK_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (bus.bf_valid &&
                 ((state_q == IDLE) || (state_q == DONE) || (acc_cnt == ACC_MAX))) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun_err = overrun_q;
`else
  assign overrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_writeback_addr_gen.sv
// Bench for fft_writeback_addr_gen: stage-2 and stage-4 instances fed the same pairs,
// writes checked against a per-instance scoreboard of expected (address, data).
module tb_fft_writeback_addr_gen;

  localparam int N = 16;

  typedef struct packed {
    logic [3:0]  ptr;
    logic [31:0] data;
    logic        last;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stage = 1'b0;
  logic        bf_valid = 1'b0;
  logic [31:0] bf_x = '0;
  logic [31:0] bf_y = '0;
  logic        stage_done2, stage_done4, overrun2, overrun4;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   b_idx   = 0;
  int   run [2];
  int   max_run [2];
  int   done_cnt [2];
  logic exp_done [2];
  logic exp_done_prev [2];
  logic saw_stall;
  ent_t exp_q [2][$];

`ifdef WB_OVERRUN_CHECK_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  fft_writeback_addr_gen_if #(.SIZE(4), .DATA_W(32)) ifc2 ();
  fft_writeback_addr_gen_if #(.SIZE(4), .DATA_W(32)) ifc4 ();

  assign ifc2.bf_valid = bf_valid;
  assign ifc2.bf_x     = bf_x;
  assign ifc2.bf_y     = bf_y;
  assign ifc4.bf_valid = bf_valid;
  assign ifc4.bf_x     = bf_x;
  assign ifc4.bf_y     = bf_y;

  fft_writeback_addr_gen #(.stage_FFT(2), .N(16), .SIZE(4), .DATA_W(32), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .bus(ifc2.slave),
    .stage_done(stage_done2), .overrun_err(overrun2)
  );

  fft_writeback_addr_gen #(.stage_FFT(4), .N(16), .SIZE(4), .DATA_W(32), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .bus(ifc4.slave),
    .stage_done(stage_done4), .overrun_err(overrun4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] top_addr(input int s, input int b);
    int half;
    half = 1 << (s - 1);
    return 4'((b / half) * 2 * half + (b % half));
  endfunction

  task automatic push_expected(input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < 2; i++) begin
      int s;
      logic [3:0] t;
      s = (i == 0) ? 2 : 4;
      t = top_addr(s, b_idx);
      exp_q[i].push_back('{t, x, 1'b0});
      exp_q[i].push_back('{4'(t + 4'(1 << (s - 1))), y, (b_idx == N/2 - 1)});
    end
  endtask

  task automatic mon(input int i, input logic en, input logic [3:0] ptr,
                     input logic [31:0] data, input logic done);
    string tg;
    logic  last;
    ent_t  e;
    tg   = (i == 0) ? "s2" : "s4";
    last = 1'b0;
    if (en) begin
      if (exp_q[i].size() == 0) begin
        check({tg, " unexpected en_wr"}, 64'(en), 64'd0);
      end else begin
        e = exp_q[i].pop_front();
        check({tg, " wr_ptr"}, 64'(ptr), 64'(e.ptr));
        check({tg, " wr_data"}, 64'(data), 64'(e.data));
        last = e.last;
      end
      run[i]++;
      if (run[i] > max_run[i]) max_run[i] = run[i];
    end else begin
      run[i] = 0;
    end
    if (done || exp_done[i] || exp_done_prev[i])
      check({tg, " stage_done"}, 64'(done), 64'(exp_done[i]));
    if (done) done_cnt[i]++;
    exp_done_prev[i] = exp_done[i];
    exp_done[i]      = en && last;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ifc2.en_wr, ifc2.wr_ptr, ifc2.wr_data, stage_done2);
      mon(1, ifc4.en_wr, ifc4.wr_ptr, ifc4.wr_data, stage_done4);
    end
  end

  task automatic flush_model();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      run[i] = 0;
      max_run[i] = 0;
      done_cnt[i] = 0;
      exp_done[i] = 1'b0;
      exp_done_prev[i] = 1'b0;
    end
    b_idx = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start_stage = 1'b1;
    @(posedge clk);
    #1 start_stage = 1'b0;
  endtask

  task automatic begin_stage();
    b_idx = 0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      max_run[i] = 0;
    end
    saw_stall = 1'b0;
    pulse_start();
  endtask

  task automatic send_pairs(input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      logic ok;
      ok = 1'b0;
      bf_valid = 1'b1;
      bf_x = $urandom;
      bf_y = $urandom;
      for (int w = 0; w < 100 && !ok; w++) begin
        @(negedge clk);
        if (ifc2.bf_ready) ok = 1'b1;
        else               saw_stall = 1'b1;
        @(posedge clk);
      end
      if (!ok) begin
        check("accept timeout", 64'd0, 64'd1);
        #1 bf_valid = 1'b0;
        return;
      end
      push_expected(bf_x, bf_y);
      b_idx++;
      #1 bf_valid = 1'b0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_ready_low_after_last();
    @(negedge clk);
    check("ready after N/2 s2", 64'(ifc2.bf_ready), 64'd0);
    check("ready after N/2 s4", 64'(ifc4.bf_ready), 64'd0);
  endtask

  task automatic wait_stage_end();
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (done_cnt[0] >= 1 && done_cnt[1] >= 1) break;
    end
    repeat (3) @(negedge clk);
    check("done count s2", 64'(done_cnt[0]), 64'd1);
    check("done count s4", 64'(done_cnt[1]), 64'd1);
    check("leftover writes s2", 64'(exp_q[0].size()), 64'd0);
    check("leftover writes s4", 64'(exp_q[1].size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " s2"}, {ifc2.bf_ready, ifc2.en_wr, ifc2.wr_ptr, ifc2.wr_data, stage_done2, overrun2}, 64'd0);
    check({tag, " s4"}, {ifc4.bf_ready, ifc4.en_wr, ifc4.wr_ptr, ifc4.wr_data, stage_done4, overrun4}, 64'd0);
  endtask

  initial begin
    logic any_ready, any_en;
    flush_model();
    saw_stall = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset values");
    rst_n = 1'b1;

    // idle valid: nothing accepted or written, overrun flagged only in the checked build
    any_ready = 1'b0;
    any_en    = 1'b0;
    @(posedge clk);
    #1 bf_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      any_ready |= ifc2.bf_ready | ifc4.bf_ready;
      any_en    |= ifc2.en_wr | ifc4.en_wr;
    end
    #1 bf_valid = 1'b0;
    check("idle bf_ready", 64'(any_ready), 64'd0);
    check("idle en_wr", 64'(any_en), 64'd0);
    check("overrun after idle valid s2", 64'(overrun2), 64'(EXP_OVR));
    check("overrun after idle valid s4", 64'(overrun4), 64'(EXP_OVR));

    // back-to-back stage: continuous writes and FIFO back-pressure
    begin_stage();
    send_pairs(8, 0);
    check_ready_low_after_last();
    wait_stage_end();
    check("en_wr run s2", 64'(max_run[0]), 64'd16);
    check("en_wr run s4", 64'(max_run[1]), 64'd16);
    check("ready stall seen", 64'(saw_stall), 64'd1);
    check("overrun sticky s2", 64'(overrun2), 64'(EXP_OVR));
    check("overrun sticky s4", 64'(overrun4), 64'(EXP_OVR));

    // sparse pairs: FSM drops back to ARMED between writes
    begin_stage();
    send_pairs(8, 3);
    check_ready_low_after_last();
    wait_stage_end();
    check("en_wr run gapped s2", 64'(max_run[0]), 64'd2);

    // reset mid-stage discards everything
    begin_stage();
    send_pairs(3, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-stage reset");
    flush_model();
    @(posedge clk);
    #3 rst_n = 1'b1;
    begin_stage();
    send_pairs(8, 1);
    check_ready_low_after_last();
    wait_stage_end();

    // start_stage re-pulsed mid-stage is ignored
    begin_stage();
    send_pairs(3, 0);
    pulse_start();
    send_pairs(5, 0);
    pulse_start();
    check_ready_low_after_last();
    wait_stage_end();
    check("overrun clean run s2", 64'(overrun2), 64'd0);
    check("overrun clean run s4", 64'(overrun4), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
